scan_ctrl_l1: RTL and testbench

//   Layer-1 window-scan initiator. Walks output coordinates x (innermost), y, k, j (outermost).
//   At every row end it issues the x_zero strobe to the layer-1 temp phase counter.
//   It then stalls until that counter returns its end-of-phase pulse (temp_done).

---
 rtl/scan_ctrl_l1.sv | 165 ++++++++++++++++
 tb/tb_scan_ctrl_l1.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_ctrl_l1.sv
// Layer-1 window-scan initiator.
// Walks the output coordinates with x innermost, then y, then k, and j outermost.
// At the end of each row it sends x_zero to the temp phase counter.
// It then stalls until that counter answers with temp_done.
// Handshake: x_zero is a one-cycle request. temp_done is honoured only while in WAIT,
// and it is sampled on every WAIT cycle, including the cycle in which x_zero is high.
// Stray temp_done pulses seen in other states are dropped.
module scan_ctrl_l1 #(
    parameter int X_DIM = 29,
    parameter int Y_DIM = 29,
    parameter int K_DIM = 2,
    parameter int J_DIM = 2,
    parameter int XW    = (X_DIM > 1) ? $clog2(X_DIM) : 1,
    parameter int YW    = (Y_DIM > 1) ? $clog2(Y_DIM) : 1,
    parameter int KW    = (K_DIM > 1) ? $clog2(K_DIM) : 1,
    parameter int JW    = (J_DIM > 1) ? $clog2(J_DIM) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          temp_done,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [KW-1:0] k,
    output logic [JW-1:0] j,
    output logic          addr_valid,
    output logic          x_zero,
    output logic          busy,
    output logic          done,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        WAIT = 2'd2,
        FIN  = 2'd3
    } state_e;

    localparam logic [XW-1:0] X_LAST = XW'(X_DIM - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_DIM - 1);
    localparam logic [KW-1:0] K_LAST = KW'(K_DIM - 1);
    localparam logic [JW-1:0] J_LAST = JW'(J_DIM - 1);

    state_e        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [KW-1:0] k_q, k_d;
    logic [JW-1:0] j_q, j_d;
    logic          addr_valid_q, addr_valid_d;
    logic          x_zero_q, x_zero_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Next-state and next-output logic; every output is registered from these _d values
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        k_d          = k_q;
        j_d          = j_q;
        addr_valid_d = 1'b0;
        x_zero_d     = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d      = SCAN;
                    x_d          = '0;
                    y_d          = '0;
                    k_d          = '0;
                    j_d          = '0;
                    addr_valid_d = 1'b1;
                    busy_d       = 1'b1;
                end
            end
            SCAN: begin
                busy_d = 1'b1;
                if (x_q != X_LAST) begin
                    x_d          = x_q + XW'(1);
                    addr_valid_d = 1'b1;
                end else begin
                    x_d      = '0;
                    x_zero_d = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                busy_d = 1'b1;
                x_d    = '0;
                if (temp_done) begin
                    if (y_q == Y_LAST && k_q == K_LAST && j_q == J_LAST) begin
                        // Last row done: clear the coordinates and pulse done while busy drops
                        state_d = FIN;
                        y_d     = '0;
                        k_d     = '0;
                        j_d     = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d      = SCAN;
                        addr_valid_d = 1'b1;
                        if (y_q != Y_LAST) begin
                            y_d = y_q + YW'(1);
                        end else begin
                            y_d = '0;
                            if (k_q != K_LAST) begin
                                k_d = k_q + KW'(1);
                            end else begin
                                k_d = '0;
                                j_d = j_q + JW'(1);
                            end
                        end
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; an asynchronous reset aborts any scan in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            k_q          <= '0;
            j_q          <= '0;
            addr_valid_q <= 1'b0;
            x_zero_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            k_q          <= k_d;
            j_q          <= j_d;
            addr_valid_q <= addr_valid_d;
            x_zero_q     <= x_zero_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign k          = k_q;
    assign j          = j_q;
    assign addr_valid = addr_valid_q;
    assign x_zero     = x_zero_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_scan_ctrl_l1.sv
// Directed testbench for scan_ctrl_l1 using the default dimensions (29 x 29 x 2 x 2).
// Inputs change 1 ns after each rising edge, and outputs are observed at that same point.
module tb_scan_ctrl_l1;

    localparam int XW = 5;
    localparam int YW = 5;
    localparam int KW = 1;
    localparam int JW = 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          temp_done;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [KW-1:0] k;
    logic [JW-1:0] j;
    logic          addr_valid;
    logic          x_zero;
    logic          busy;
    logic          done;
    logic [1:0]    state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [XW-1:0] exp_q[$];

    scan_ctrl_l1 dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .temp_done  (temp_done),
        .x          (x),
        .y          (y),
        .k          (k),
        .j          (j),
        .addr_valid (addr_valid),
        .x_zero     (x_zero),
        .busy       (busy),
        .done       (done),
        .state_dbg  (state_dbg)
    );

    // Clock generation
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run to the end of the current row, then answer x_zero with temp_done immediately
    task automatic advance_row();
        int guard;
        guard = 0;
        while (x_zero !== 1'b1 && guard < 100) begin
            step();
            guard++;
        end
        n_checks++;
        if (guard >= 100) begin
            n_fail++;
            $display("FAIL advance_row_timeout: x_zero not seen within %0d cycles (required within 100)", guard);
        end
        temp_done = 1'b1;
        step();
        temp_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; temp_done = 1'b0;
        repeat (3) step();
        n_checks++;
        if (x !== '0 || y !== '0 || k !== '0 || j !== '0 || addr_valid !== 1'b0 ||
            x_zero !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: x=%0d y=%0d k=%0d j=%0d av=%b xz=%b busy=%b done=%b, required all 0",
                     x, y, k, j, addr_valid, x_zero, busy, done);
        end
        n_checks++;
        if (state_dbg !== S_IDLE) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d required %0d", state_dbg, S_IDLE);
        end
        rst = 1'b0; start = 1'b0;
        repeat (5) begin
            step();
            n_checks++;
            if (x_zero !== 1'b0 || busy !== 1'b0 || addr_valid !== 1'b0 || state_dbg !== S_IDLE) begin
                n_fail++;
                $display("FAIL post_reset_idle: xz=%b busy=%b av=%b state=%0d, required 0/0/0/0",
                         x_zero, busy, addr_valid, state_dbg);
            end
        end
    endtask

    task automatic test_row();
        logic [XW-1:0] exp_x;
        for (int i = 0; i < 29; i++) exp_q.push_back(XW'(i));
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 29; i++) begin
            exp_x = exp_q.pop_front();
            n_checks++;
            if (addr_valid !== 1'b1 || x !== exp_x || y !== '0 || busy !== 1'b1 || x_zero !== 1'b0) begin
                n_fail++;
                $display("FAIL row_scan: av=%b x=%0d y=%0d busy=%b xz=%b, required 1/%0d/0/1/0",
                         addr_valid, x, y, busy, x_zero, exp_x);
            end
            step();
        end
        n_checks++;
        if (x_zero !== 1'b1 || addr_valid !== 1'b0 || x !== '0 || state_dbg !== S_WAIT) begin
            n_fail++;
            $display("FAIL row_end_strobe: xz=%b av=%b x=%0d state=%0d, required 1/0/0/%0d",
                     x_zero, addr_valid, x, state_dbg, S_WAIT);
        end
        step();
        n_checks++;
        if (x_zero !== 1'b0 || addr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL row_strobe_once: xz=%b av=%b, required 0/0", x_zero, addr_valid);
        end
        temp_done = 1'b1;
        step();
        temp_done = 1'b0;
        n_checks++;
        if (addr_valid !== 1'b1 || x !== '0 || y !== 5'd1 || k !== '0 || j !== '0) begin
            n_fail++;
            $display("FAIL row_resume: av=%b x=%0d y=%0d k=%0d j=%0d, required 1/0/1/0/0",
                     addr_valid, x, y, k, j);
        end
    endtask

    task automatic test_stall();
        int guard;
        guard = 0;
        while (x_zero !== 1'b1 && guard < 100) begin
            step();
            guard++;
        end
        n_checks++;
        if (guard >= 100) begin
            n_fail++;
            $display("FAIL stall_reach_wait: x_zero not seen within %0d cycles (required within 100)", guard);
        end
        temp_done = 1'b0;
        repeat (50) begin
            step();
            n_checks++;
            if (addr_valid !== 1'b0 || x !== '0 || y !== 5'd1 || k !== '0 || j !== '0 ||
                x_zero !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_frozen: av=%b x=%0d y=%0d k=%0d j=%0d xz=%b busy=%b, required 0/0/1/0/0/0/1",
                         addr_valid, x, y, k, j, x_zero, busy);
            end
        end
        temp_done = 1'b1;
        step();
        temp_done = 1'b0;
        n_checks++;
        if (addr_valid !== 1'b1 || x !== '0 || y !== 5'd2) begin
            n_fail++;
            $display("FAIL stall_resume: av=%b x=%0d y=%0d, required 1/0/2", addr_valid, x, y);
        end
    endtask

    task automatic test_carry();
        int guard;
        guard = 0;
        while (!(y === 5'd28 && k === 1'b0) && guard < 200) begin
            advance_row();
            guard++;
        end
        advance_row();
        n_checks++;
        if (y !== '0 || k !== 1'b1 || j !== 1'b0 || addr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL carry_y_into_k: y=%0d k=%0d j=%0d av=%b, required 0/1/0/1", y, k, j, addr_valid);
        end
        guard = 0;
        while (!(y === 5'd28 && k === 1'b1) && guard < 200) begin
            advance_row();
            guard++;
        end
        advance_row();
        n_checks++;
        if (y !== '0 || k !== 1'b0 || j !== 1'b1 || addr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL carry_k_into_j: y=%0d k=%0d j=%0d av=%b, required 0/0/1/1", y, k, j, addr_valid);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_full_scan();
        int av_cnt, xz_cnt, done_cnt, cyc;
        logic prev_busy;
        av_cnt = 0; xz_cnt = 0; done_cnt = 0; cyc = 0; prev_busy = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        while (done_cnt == 0 && cyc < 5000) begin
            if (addr_valid === 1'b1) av_cnt++;
            if (x_zero === 1'b1) xz_cnt++;
            temp_done = x_zero;
            if (done === 1'b1) begin
                done_cnt++;
                n_checks++;
                if (busy !== 1'b0 || prev_busy !== 1'b1 || x !== '0 || y !== '0 || k !== '0 || j !== '0) begin
                    n_fail++;
                    $display("FAIL full_done_cycle: busy=%b prev_busy=%b x=%0d y=%0d k=%0d j=%0d, required 0/1/0/0/0/0",
                             busy, prev_busy, x, y, k, j);
                end
            end else begin
                prev_busy = busy;
                step();
                cyc++;
            end
        end
        temp_done = 1'b0;
        n_checks++;
        if (xz_cnt != 116) begin
            n_fail++;
            $display("FAIL full_x_zero_count: got %0d required 116", xz_cnt);
        end
        n_checks++;
        if (av_cnt != 3364) begin
            n_fail++;
            $display("FAIL full_valid_count: got %0d required 3364", av_cnt);
        end
        n_checks++;
        if (done_cnt != 1) begin
            n_fail++;
            $display("FAIL full_done_seen: got %0d done pulses within %0d cycles, required 1", done_cnt, cyc);
        end
        repeat (4) begin
            step();
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0 || state_dbg !== S_IDLE || addr_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL full_after_done: done=%b busy=%b state=%0d av=%b, required 0/0/%0d/0",
                         done, busy, state_dbg, addr_valid, S_IDLE);
            end
        end
    endtask

    task automatic test_corners();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 28; i++) begin
            temp_done = (i % 2 == 0);
            start     = ((i / 2) % 2 == 1);
            step();
            n_checks++;
            if (x !== XW'(i + 1) || y !== '0 || addr_valid !== 1'b1 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL corner_scan_ignores: x=%0d y=%0d av=%b busy=%b, required %0d/0/1/1",
                         x, y, addr_valid, busy, i + 1);
            end
        end
        temp_done = 1'b0; start = 1'b0;
        step();
        n_checks++;
        if (x_zero !== 1'b1 || state_dbg !== S_WAIT) begin
            n_fail++;
            $display("FAIL corner_row_end: xz=%b state=%0d, required 1/%0d", x_zero, state_dbg, S_WAIT);
        end
        start = 1'b1;
        repeat (3) begin
            step();
            n_checks++;
            if (state_dbg !== S_WAIT || y !== '0 || addr_valid !== 1'b0 || x_zero !== 1'b0) begin
                n_fail++;
                $display("FAIL corner_start_in_wait: state=%0d y=%0d av=%b xz=%b, required %0d/0/0/0",
                         state_dbg, y, addr_valid, x_zero, S_WAIT);
            end
        end
        start = 1'b0;
        rst = 1'b1;
        step();
        n_checks++;
        if (x !== '0 || y !== '0 || k !== '0 || j !== '0 || addr_valid !== 1'b0 || x_zero !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || state_dbg !== S_IDLE) begin
            n_fail++;
            $display("FAIL corner_reset_mid_wait: x=%0d y=%0d k=%0d j=%0d av=%b xz=%b busy=%b done=%b state=%0d, required all 0",
                     x, y, k, j, addr_valid, x_zero, busy, done, state_dbg);
        end
        rst = 1'b0;
        step();
        n_checks++;
        if (x_zero !== 1'b0 || busy !== 1'b0 || state_dbg !== S_IDLE) begin
            n_fail++;
            $display("FAIL corner_reset_release: xz=%b busy=%b state=%0d, required 0/0/%0d",
                     x_zero, busy, state_dbg, S_IDLE);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if (x !== '0 || y !== '0 || k !== '0 || j !== '0 || addr_valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL corner_restart: x=%0d y=%0d k=%0d j=%0d av=%b busy=%b, required 0/0/0/0/1/1",
                     x, y, k, j, addr_valid, busy);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; temp_done = 1'b0;
        test_reset();
        test_row();
        test_stall();
        test_carry();
        test_full_scan();
        test_corners();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
